// File: rtl/mult_sequencer_if.sv
// Operand/result bundle between the EX stage and the shift-add multiply sequencer.
// The cancel signal exists only when MULT_CANCEL_EN is defined.
interface mult_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef MULT_CANCEL_EN
  logic             cancel;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, a, b,
`ifdef MULT_CANCEL_EN
    output cancel,
`endif
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, a, b,
`ifdef MULT_CANCEL_EN
    input  cancel,
`endif
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_sequencer.sv
// Multi-cycle shift-add MULT/MULTU sequencer: WIDTH add iterations, then sign fix-up into HI/LO.
// Optional flush input enabled by defining MULT_CANCEL_EN.
module mult_sequencer #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  mult_sequencer_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0]     ONE_W    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0]   ONE_2W   = (2*WIDTH)'(1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   mag_a_q;
  logic [WIDTH-1:0]   acc_hi_q;
  logic [WIDTH-1:0]   acc_lo_q;
  logic               neg_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [WIDTH:0]     sum_d;
  logic [2*WIDTH-1:0] prod_d;
  logic               cancel_w;

  // 0x8000_0000 maps to itself and is then treated as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             sgn);
    logic signed [WIDTH-1:0] xs;
    xs = x;
    return (sgn && xs[WIDTH-1]) ? (~x + ONE_W) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                    input logic               neg);
    return neg ? (~p + ONE_2W) : p;
  endfunction

`ifdef MULT_CANCEL_EN
  assign cancel_w = bus.cancel;
`else
  assign cancel_w = 1'b0;
`endif

  always_comb begin
    sum_d  = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? mag_a_q : '0)};
    prod_d = apply_sign({acc_hi_q, acc_lo_q}, neg_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mag_a_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mag_a_q  <= magnitude(bus.a, bus.is_signed);
            acc_lo_q <= magnitude(bus.b, bus.is_signed);
            acc_hi_q <= '0;
            neg_q    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end
        end
        CALC: begin
          if (cancel_w) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            // Carry-out becomes the new MSB as the accumulator pair shifts right.
            {acc_hi_q, acc_lo_q} <= {sum_d, acc_lo_q[WIDTH-1:1]};
            cnt_q <= cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) state_q <= FIX;
          end
        end
        FIX: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
          if (!cancel_w) begin
            {hi_q, lo_q} <= prod_d;
            done_q       <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed self-checking bench for mult_sequencer (hand-computed products, latency, hold, abort).
module tb_mult_sequencer;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [W-1:0] prev_hi;
  logic [W-1:0] prev_lo;

  mult_sequencer_if #(.WIDTH(W)) bus ();

  mult_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one op and follow it to done; inj>0 pulses a stray start (2*2) at that cycle.
  task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] eh,
                        input logic [W-1:0] el, input int inj);
    int   cyc;
    logic busy_ok;
    logic held_ok;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.a         = av;
    bus.b         = bv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc     = 0;
    busy_ok = 1'b1;
    held_ok = 1'b1;
    check({tag, "_busy_start"}, 64'(bus.busy), 64'd1);
    while (!bus.done && cyc < 60) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.hi !== prev_hi || bus.lo !== prev_lo) held_ok = 1'b0;
      if (inj != 0) begin
        bus.start = (cyc == inj);
        bus.a     = 32'd2;
        bus.b     = 32'd2;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    check({tag, "_latency"},   64'(cyc),      64'd33);
    check({tag, "_busy_held"}, 64'(busy_ok),  64'd1);
    check({tag, "_hilo_held"}, 64'(held_ok),  64'd1);
    check({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
    check({tag, "_hi"},        64'(bus.hi),   64'(eh));
    check({tag, "_lo"},        64'(bus.lo),   64'(el));
    prev_hi = eh;
    prev_lo = el;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_done;
    n_cmp = 0;
    n_err = 0;
    prev_hi = '0;
    prev_lo = '0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.a = '0;
    bus.b = '0;
`ifdef MULT_CANCEL_EN
    bus.cancel = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi",   64'(bus.hi),   64'd0);
    check("rst_lo",   64'(bus.lo),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("multu_6x7", 1'b0, 32'd6, 32'd7, 32'h0000_0000, 32'h0000_002A, 0);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(bus.done), 64'd0);

    run_op("mult_m3x5",   1'b1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    run_op("multu_ffxff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("mult_ffxff",  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0);
    run_op("mult_min2",   1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
    run_op("mult_zero",   1'b1, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 0);

    // Stray start mid-op is ignored, then a start in the done cycle is accepted.
    run_op("ignore_start", 1'b0, 32'd6, 32'd7, 32'h0, 32'd42, 5);
    run_op("b2b_3x3",      1'b0, 32'd3, 32'd3, 32'h0, 32'd9,  0);

    // Asynchronous reset at iteration 10 aborts the op.
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.a = 32'd6; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_hi",   64'(bus.hi),   64'd0);
    check("abort_lo",   64'(bus.lo),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_hi = '0;
    prev_lo = '0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) seen_done = 1'b1;
    end
    check("abort_no_done", 64'(seen_done), 64'd0);
    run_op("post_rst_5x5", 1'b0, 32'd5, 32'd5, 32'h0, 32'd25, 0);

`ifdef MULT_CANCEL_EN
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.a = 32'd6; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    check("cancel_busy", 64'(bus.busy), 64'd0);
    check("cancel_hi",   64'(bus.hi),   64'd0);
    check("cancel_lo",   64'(bus.lo),   64'd25);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) seen_done = 1'b1;
    end
    check("cancel_no_done", 64'(seen_done), 64'd0);
    run_op("post_cancel_6x7", 1'b0, 32'd6, 32'd7, 32'h0, 32'd42, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
